// File: rtl/mem_stage_v.sv
// Memory-access pipeline stage: byte/half/word loads and stores over a ready-handshake port.
// Optional wait-state abort is enabled by defining MEM_TIMEOUT_EN.
module mem_stage_v #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [6:0]  op,
  input  logic [2:0]  funct3,
  input  logic [4:0]  rd,
  input  logic        reg_write,
  input  logic [31:0] alu_result,
  input  logic [31:0] s_data,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        out_valid,
  output logic        out_reg_write,
  output logic [4:0]  out_rd,
  output logic [31:0] memwb_result,
  output logic        mem_fault
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      r_state, n_state;
  logic        r_dmem_req, n_dmem_req;
  logic        r_dmem_we, n_dmem_we;
  logic [31:0] r_dmem_addr, n_dmem_addr;
  logic [3:0]  r_dmem_be, n_dmem_be;
  logic [31:0] r_dmem_wdata, n_dmem_wdata;
  logic        r_out_valid, n_out_valid;
  logic        r_out_reg_write, n_out_reg_write;
  logic [4:0]  r_out_rd, n_out_rd;
  logic [31:0] r_memwb_result, n_memwb_result;
  logic        r_mem_fault, n_mem_fault;

  logic        w_is_load, w_is_store, w_is_mem;
  logic        w_size_ok, w_align_ok, w_mem_ok;
  logic [31:0] w_lane, w_load_data, w_st_wdata;
  logic [3:0]  w_st_be;
  logic        w_timeout;

  // Access decode: legality of size/sign code and natural alignment
  always_comb begin
    w_is_load  = (op == OP_LOAD);
    w_is_store = (op == OP_STORE);
    w_is_mem   = w_is_load || w_is_store;
    if (w_is_load)
      w_size_ok = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                  (funct3 == 3'b100) || (funct3 == 3'b101);
    else
      w_size_ok = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
    case (funct3[1:0])
      2'b01:   w_align_ok = !alu_result[0];
      2'b10:   w_align_ok = (alu_result[1:0] == 2'b00);
      default: w_align_ok = 1'b1;
    endcase
    w_mem_ok = w_size_ok && w_align_ok;
  end

  // Load lane extraction and store lane replication
  always_comb begin
    w_lane = dmem_rdata >> {alu_result[1:0], 3'b000};
    case (funct3)
      3'b000:  w_load_data = {{24{w_lane[7]}}, w_lane[7:0]};
      3'b001:  w_load_data = {{16{w_lane[15]}}, w_lane[15:0]};
      3'b100:  w_load_data = {24'h000000, w_lane[7:0]};
      3'b101:  w_load_data = {16'h0000, w_lane[15:0]};
      default: w_load_data = dmem_rdata;
    endcase
    case (funct3[1:0])
      2'b00: begin
        w_st_be    = 4'(4'b0001 << alu_result[1:0]);
        w_st_wdata = {4{s_data[7:0]}};
      end
      2'b01: begin
        w_st_be    = 4'(4'b0011 << alu_result[1:0]);
        w_st_wdata = {2{s_data[15:0]}};
      end
      default: begin
        w_st_be    = 4'b1111;
        w_st_wdata = s_data;
      end
    endcase
  end

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] r_wait_cnt, n_wait_cnt;

  // Wait-state counter; zero whenever IDLE so it is clear on entry to BUSY
  always_comb begin
    n_wait_cnt = '0;
    if (r_state == BUSY && !dmem_ready && !w_timeout)
      n_wait_cnt = r_wait_cnt + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_wait_cnt <= '0;
    else        r_wait_cnt <= n_wait_cnt;
  end

  assign w_timeout = (r_state == BUSY) && !dmem_ready &&
                     (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^32'(TIMEOUT_CYCLES);
  assign w_timeout        = 1'b0;
`endif

  assign stall = (r_state == IDLE) ? (in_valid && w_is_mem && w_mem_ok)
                                   : (!dmem_ready && !w_timeout);

  // Next-state and registered output logic
  always_comb begin
    n_state         = r_state;
    n_dmem_req      = r_dmem_req;
    n_dmem_we       = r_dmem_we;
    n_dmem_addr     = r_dmem_addr;
    n_dmem_be       = r_dmem_be;
    n_dmem_wdata    = r_dmem_wdata;
    n_out_valid     = 1'b0;
    n_out_reg_write = r_out_reg_write;
    n_out_rd        = r_out_rd;
    n_memwb_result  = r_memwb_result;
    n_mem_fault     = 1'b0;
    case (r_state)
      IDLE: begin
        if (in_valid) begin
          if (w_is_mem && w_mem_ok) begin
            n_state      = BUSY;
            n_dmem_req   = 1'b1;
            n_dmem_we    = w_is_store;
            n_dmem_addr  = {alu_result[31:2], 2'b00};
            n_dmem_be    = w_st_be;
            n_dmem_wdata = w_st_wdata;
          end else if (w_is_mem) begin
            n_out_valid     = 1'b1;
            n_out_reg_write = 1'b0;
            n_out_rd        = rd;
            n_memwb_result  = alu_result;
            n_mem_fault     = 1'b1;
          end else begin
            n_out_valid     = 1'b1;
            n_out_reg_write = reg_write;
            n_out_rd        = rd;
            n_memwb_result  = alu_result;
          end
        end
      end
      BUSY: begin
        if (dmem_ready) begin
          n_state         = IDLE;
          n_dmem_req      = 1'b0;
          n_dmem_we       = 1'b0;
          n_out_valid     = 1'b1;
          n_out_rd        = rd;
          n_out_reg_write = w_is_load ? reg_write : 1'b0;
          n_memwb_result  = w_is_load ? w_load_data : alu_result;
        end else if (w_timeout) begin
          n_state         = IDLE;
          n_dmem_req      = 1'b0;
          n_dmem_we       = 1'b0;
          n_out_valid     = 1'b1;
          n_out_rd        = rd;
          n_out_reg_write = 1'b0;
          n_memwb_result  = alu_result;
          n_mem_fault     = 1'b1;
        end
      end
      default: n_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= IDLE;
      r_dmem_req      <= 1'b0;
      r_dmem_we       <= 1'b0;
      r_dmem_addr     <= '0;
      r_dmem_be       <= '0;
      r_dmem_wdata    <= '0;
      r_out_valid     <= 1'b0;
      r_out_reg_write <= 1'b0;
      r_out_rd        <= '0;
      r_memwb_result  <= '0;
      r_mem_fault     <= 1'b0;
    end else begin
      r_state         <= n_state;
      r_dmem_req      <= n_dmem_req;
      r_dmem_we       <= n_dmem_we;
      r_dmem_addr     <= n_dmem_addr;
      r_dmem_be       <= n_dmem_be;
      r_dmem_wdata    <= n_dmem_wdata;
      r_out_valid     <= n_out_valid;
      r_out_reg_write <= n_out_reg_write;
      r_out_rd        <= n_out_rd;
      r_memwb_result  <= n_memwb_result;
      r_mem_fault     <= n_mem_fault;
    end
  end

  assign dmem_req      = r_dmem_req;
  assign dmem_we       = r_dmem_we;
  assign dmem_addr     = r_dmem_addr;
  assign dmem_be       = r_dmem_be;
  assign dmem_wdata    = r_dmem_wdata;
  assign out_valid     = r_out_valid;
  assign out_reg_write = r_out_reg_write;
  assign out_rd        = r_out_rd;
  assign memwb_result  = r_memwb_result;
  assign mem_fault     = r_mem_fault;

endmodule

// File: tb/tb_mem_stage_v.sv
// Directed scoreboard bench for mem_stage_v; write-back expectations are queued at issue
// and retired whenever out_valid is seen.
module tb_mem_stage_v;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_ALU   = 7'b0110011;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [6:0]  op = '0;
  logic [2:0]  funct3 = '0;
  logic [4:0]  rd = '0;
  logic        reg_write = 1'b0;
  logic [31:0] alu_result = '0;
  logic [31:0] s_data = '0;
  logic        stall;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ready = 1'b0;
  logic [31:0] dmem_rdata = '0;
  logic        out_valid, out_reg_write;
  logic [4:0]  out_rd;
  logic [31:0] memwb_result;
  logic        mem_fault;

  mem_stage_v #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .op(op), .funct3(funct3), .rd(rd),
    .reg_write(reg_write), .alu_result(alu_result), .s_data(s_data), .stall(stall),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .out_valid(out_valid), .out_reg_write(out_reg_write), .out_rd(out_rd),
    .memwb_result(memwb_result), .mem_fault(mem_fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [31:0] res;
    logic [4:0]  rd;
    logic        rw;
    logic        flt;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, got, exp);
  endtask

  // Advance one cycle, then retire any write-back against the scoreboard
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (out_valid) begin
      if (q.size() == 0) begin
        chk("spurious_valid", 32'(out_valid), 32'd0);
      end else begin
        e = q.pop_front();
        chk("latency", 32'(cyc), 32'(e.due));
        chk("result", memwb_result, e.res);
        chk("out_rd", 32'(out_rd), 32'(e.rd));
        chk("out_reg_write", 32'(out_reg_write), 32'(e.rw));
        chk("mem_fault", 32'(mem_fault), 32'(e.flt));
      end
    end else begin
      if (q.size() > 0 && q[0].due <= cyc) begin
        chk("missing_valid", 32'(out_valid), 32'd1);
        void'(q.pop_front());
      end
      if (mem_fault) chk("fault_without_valid", 32'(mem_fault), 32'd0);
    end
  endtask

  task automatic drive(input logic [6:0] o, input logic [2:0] f3, input logic [4:0] r,
                       input logic rw, input logic [31:0] a, input logic [31:0] sd);
    in_valid = 1'b1; op = o; funct3 = f3; rd = r; reg_write = rw; alu_result = a; s_data = sd;
  endtask

  task automatic push(input int due, input logic [31:0] res, input logic [4:0] r,
                      input logic rw, input logic flt);
    exp_t e;
    e.due = due; e.res = res; e.rd = r; e.rw = rw; e.flt = flt;
    q.push_back(e);
  endtask

  task automatic alu_op(input logic [4:0] r, input logic rw, input logic [31:0] a);
    drive(OP_ALU, 3'b000, r, rw, a, 32'h0);
    #1 chk("alu_stall", 32'(stall), 32'd0);
    push(cyc + 1, a, r, rw, 1'b0);
    tick();
  endtask

  task automatic fault_op(input logic [6:0] o, input logic [2:0] f3, input logic [4:0] r,
                          input logic [31:0] a);
    drive(o, f3, r, 1'b1, a, 32'h5555_5555);
    dmem_ready = 1'b1;
    #1 chk("fault_stall", 32'(stall), 32'd0);
    push(cyc + 1, a, r, 1'b0, 1'b1);
    tick();
    chk("fault_no_req", 32'(dmem_req), 32'd0);
    dmem_ready = 1'b0;
  endtask

  // Legal load/store with a given number of wait cycles; dmem_ready is held high in the
  // presentation cycle to show it is ignored while IDLE
  task automatic mem_op(input logic [6:0] o, input logic [2:0] f3, input logic [4:0] r,
                        input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rdat,
                        input int waits, input logic [31:0] exp_res, input logic [3:0] exp_be,
                        input logic [31:0] exp_wd);
    drive(o, f3, r, 1'b1, a, sd);
    dmem_ready = 1'b1;
    dmem_rdata = rdat;
    #1 chk("mem_present_stall", 32'(stall), 32'd1);
    push(cyc + 2 + waits, exp_res, r, (o == OP_LOAD), 1'b0);
    tick();
    dmem_ready = 1'b0;
    chk("dmem_req", 32'(dmem_req), 32'd1);
    chk("dmem_addr", dmem_addr, {a[31:2], 2'b00});
    chk("dmem_we", 32'(dmem_we), 32'(o == OP_STORE));
    if (o == OP_STORE) begin
      chk("dmem_be", 32'(dmem_be), 32'(exp_be));
      chk("dmem_wdata", dmem_wdata, exp_wd);
    end
    for (int i = 0; i < waits; i++) begin
      #1 chk("wait_stall", 32'(stall), 32'd1);
      tick();
      chk("held_addr", dmem_addr, {a[31:2], 2'b00});
      chk("held_req", 32'(dmem_req), 32'd1);
    end
    dmem_ready = 1'b1;
    #1 chk("ready_stall", 32'(stall), 32'd0);
    tick();
    chk("req_drop", 32'(dmem_req), 32'd0);
    dmem_ready = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    #3;
    chk("rst_req", 32'(dmem_req), 32'd0);
    chk("rst_we", 32'(dmem_we), 32'd0);
    chk("rst_addr", dmem_addr, 32'd0);
    chk("rst_be", 32'(dmem_be), 32'd0);
    chk("rst_wdata", dmem_wdata, 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_rw", 32'(out_reg_write), 32'd0);
    chk("rst_rd", 32'(out_rd), 32'd0);
    chk("rst_result", memwb_result, 32'd0);
    chk("rst_fault", 32'(mem_fault), 32'd0);
    #10 rst_n = 1'b1;
    tick();

    alu_op(5'd5, 1'b1, 32'h1234_5678);
    alu_op(5'd7, 1'b0, 32'hDEAD_BEEF);
    in_valid = 1'b0;
    tick();
    chk("idle_hold_result", memwb_result, 32'hDEAD_BEEF);

    mem_op(OP_LOAD, 3'b000, 5'd3, 32'h103, 32'h0, 32'h80FF_0000, 0, 32'hFFFF_FF80, 4'h0, 32'h0);
    mem_op(OP_STORE, 3'b001, 5'd9, 32'h202, 32'hAAAA_BEEF, 32'h0, 3, 32'h202, 4'b1100,
           32'hBEEF_BEEF);
    mem_op(OP_STORE, 3'b000, 5'd4, 32'h1, 32'h1234_56C3, 32'h0, 0, 32'h1, 4'b0010,
           32'hC3C3_C3C3);
    mem_op(OP_STORE, 3'b010, 5'd6, 32'h10, 32'hCAFE_F00D, 32'h0, 1, 32'h10, 4'b1111,
           32'hCAFE_F00D);
    mem_op(OP_LOAD, 3'b001, 5'd8, 32'h2, 32'h0, 32'h8001_0000, 2, 32'hFFFF_8001, 4'h0, 32'h0);
    mem_op(OP_LOAD, 3'b101, 5'd10, 32'h2, 32'h0, 32'h8001_0000, 0, 32'h0000_8001, 4'h0, 32'h0);
    mem_op(OP_LOAD, 3'b010, 5'd11, 32'h44, 32'h0, 32'h7654_3210, 0, 32'h7654_3210, 4'h0, 32'h0);

    fault_op(OP_LOAD, 3'b010, 5'd12, 32'h105);
    in_valid = 1'b0;
    tick();
    chk("fault_pulse_end", 32'(mem_fault), 32'd0);
    fault_op(OP_STORE, 3'b001, 5'd13, 32'h203);
    fault_op(OP_LOAD, 3'b011, 5'd14, 32'h200);
    fault_op(OP_STORE, 3'b100, 5'd15, 32'h300);
    alu_op(5'd1, 1'b1, 32'h0000_0042);

    // Reset asserted mid-transaction abandons it
    drive(OP_LOAD, 3'b010, 5'd2, 1'b1, 32'h40, 32'h0);
    dmem_ready = 1'b0;
    tick();
    chk("busy_req", 32'(dmem_req), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_req", 32'(dmem_req), 32'd0);
    chk("midrst_valid", 32'(out_valid), 32'd0);
    q.delete();
    in_valid = 1'b0;
    #1 rst_n = 1'b1;
    tick();
    mem_op(OP_LOAD, 3'b100, 5'd16, 32'h1, 32'h0, 32'h0000_9A00, 0, 32'h0000_009A, 4'h0, 32'h0);

    // Memory that never answers
    drive(OP_LOAD, 3'b010, 5'd17, 1'b1, 32'h80, 32'h0);
    dmem_ready = 1'b0;
    #1 chk("to_present_stall", 32'(stall), 32'd1);
`ifdef MEM_TIMEOUT_EN
    push(cyc + 5, 32'h80, 5'd17, 1'b0, 1'b1);
    tick();
    for (int i = 0; i < 3; i++) begin
      #1 chk("to_wait_stall", 32'(stall), 32'd1);
      tick();
    end
    #1 chk("to_release_stall", 32'(stall), 32'd0);
    tick();
    chk("to_req_drop", 32'(dmem_req), 32'd0);
    in_valid = 1'b0;
    tick();
`else
    tick();
    for (int i = 0; i < 8; i++) tick();
    chk("hang_stall", 32'(stall), 32'd1);
    chk("hang_req", 32'(dmem_req), 32'd1);
    #1 rst_n = 1'b0;
    in_valid = 1'b0;
    #1 rst_n = 1'b1;
    tick();
`endif
    tick();
    chk("scoreboard_drained", 32'(q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_stage_v.md
# mem_stage_v

Memory-access stage of the 5-stage pipeline, directly downstream of the execute stage. Consumes the ALU result and forwarded store data, performs byte/half/word loads and stores over a ready-handshake data-memory port, and produces the registered write-back value fed to MEM/WB and back to the forwarding unit as `memwb_result`. Stalls the upstream pipeline while a memory transaction is outstanding.

## Interface
- `TIMEOUT_CYCLES`, 64: wait-state limit before abort; only used with `MEM_TIMEOUT_EN`.
- `clk`  in  1  pipeline clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  EX/MEM register holds a valid instruction.
- `op`  in  7  RISC-V opcode; load = 7'b0000011, store = 7'b0100011, all others pass through.
- `funct3`  in  3  access size/sign.
- `rd`  in  5  destination register.
- `reg_write`  in  1  instruction writes `rd`.
- `alu_result`  in  32  EX result; the byte address for loads/stores.
- `s_data`  in  32  forwarded store data.
- `stall`  out  1  combinational; upstream holds all inputs while high.
- `dmem_req`, `dmem_we`  out  1  request, write enable.
- `dmem_addr`  out  32  word address, `{alu_result[31:2],2'b00}`.
- `dmem_be`  out  4  byte enables.
- `dmem_wdata`  out  32  lane-replicated store data.
- `dmem_ready`  in  1  memory completes the request this cycle.
- `dmem_rdata`  in  32  read data, valid when `dmem_ready`.
- `out_valid`, `out_reg_write`  out  1  MEM/WB valid, write enable.
- `out_rd`  out  5  MEM/WB destination.
- `memwb_result`  out  32  write-back value.
- `mem_fault`  out  1  one-cycle pulse with `out_valid` on a faulted access.

## Operation
- States: IDLE, BUSY.
- IDLE, `in_valid`, non-memory op: at next edge `out_valid`=1, `memwb_result`=`alu_result`, `rd`/`reg_write` copied. `stall`=0.
- IDLE, `in_valid`, legal aligned load/store: `stall`=1; at next edge -> BUSY, `dmem_req`=1 with addr/be/we/wdata registered.
- BUSY: request fields held stable. `stall` = !`dmem_ready`. On `dmem_ready`=1: edge -> IDLE, `dmem_req`=0, `out_valid`=1. Load: `memwb_result` = extracted data. Store: `memwb_result`=`alu_result`, `out_reg_write`=0.
- Loads (funct3): 000 LB sign-ext byte, 001 LH sign-ext half, 010 LW, 100 LBU, 101 LHU. Lane = `dmem_rdata >> (8*alu_result[1:0])`.
- Stores: 000 SB `be`=4'b0001<<a[1:0], wdata = byte x4; 001 SH `be`=4'b0011<<a[1:0], wdata = half x2; 010 SW `be`=4'b1111.
- Fault (no request issued): half with a[0]=1, word with a[1:0]!=0, other funct3. Next edge: `out_valid`=1, `out_reg_write`=0, `mem_fault`=1, `memwb_result`=`alu_result`; `stall`=0.
- `in_valid`=0 in IDLE: `out_valid`=0 next edge; other outputs hold.

## Timing
- Reset (async, any state): state IDLE; `dmem_req`, `dmem_we`, `out_valid`, `out_reg_write`, `mem_fault`=0; `dmem_addr`, `dmem_be`, `dmem_wdata`, `memwb_result`, `out_rd`=0. Outstanding memory transaction is abandoned; memory must tolerate dropped requests.
- Non-memory op: 1-cycle latency, full throughput.
- Memory op, zero-wait memory (`dmem_ready` high the cycle `dmem_req` rises): `out_valid` 2 cycles after presentation; each wait cycle adds one.
- `dmem_ready` ignored in IDLE. Back-to-back memory ops: next op presented the cycle after the ready cycle, no bubble.
- `out_valid` and `mem_fault` are one-cycle pulses per instruction.

## Configuration
- `MEM_TIMEOUT_EN` defined: wait counter cleared on entry to BUSY, incremented each BUSY cycle without `dmem_ready`. When it reaches `TIMEOUT_CYCLES` without ready: `dmem_req` drops, -> IDLE, `out_valid`=1, `mem_fault`=1, `out_reg_write`=0, `stall` released that cycle.
- Undefined: no counter; BUSY waits indefinitely.

## Test plan
- ALU op, `alu_result`=0x12345678, `rd`=5: `out_valid`=1, `memwb_result`=0x12345678 next cycle, `stall` never high.
- LB at 0x103, zero-wait, `dmem_rdata`=0x80FF_0000: `dmem_addr`=0x100, `memwb_result`=0xFFFFFF80, `out_valid` 2 cycles after presentation.
- SH at 0x202, `s_data`=0xAAAA_BEEF, 3 wait cycles: `dmem_be`=4'b1100, `dmem_wdata`=0xBEEFBEEF, `stall` high 4 cycles, `out_reg_write`=0.
- LW at 0x105: no `dmem_req`, `mem_fault` pulse, `out_reg_write`=0, `stall` stays 0.
- Reset asserted mid-BUSY: `dmem_req`, `out_valid` go 0 immediately; subsequent LBU at 0x001 with `dmem_rdata`=0x0000_9A00 returns 0x0000009A.
- `MEM_TIMEOUT_EN`, `TIMEOUT_CYCLES`=4, `dmem_ready` held 0: `mem_fault` pulse after 4 BUSY cycles; without macro, `stall` remains high.
